vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 640x480@60 Hz display path. It divides the board clock down to a pixel-rate enable and runs the horizontal and vertical counters. It produces the `hc`/`vc`/`blank` triplet consumed by the sprite renderers (X, O, grid) and the `hsync`/`vsync` pins driven to the connector. All outputs are registered and mutually aligned, so downstream combinational sprite logic sees coherent coordinates.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `CLK_DIV`, default 4: board clocks per pixel (100 MHz → 25 MHz); legal range ≥1.
- `SYNC_ACTIVE`, default 0: asserted level of `hsync`/`vsync`.

Ports:
- `clk`, in, 1: board clock; the only clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `hc`, out, 11: current pixel column, 0..H_TOTAL-1.
- `vc`, out, 11: current line, 0..V_TOTAL-1.
- `blank`, out, 1: high outside the visible area.
- `hsync`, out, 1: horizontal sync, polarity set by `SYNC_ACTIVE`.
- `vsync`, out, 1: vertical sync, polarity set by `SYNC_ACTIVE`.
- `pix_tick`, out, 1: one-`clk` pulse marking each pixel advance.
- `line_start`, out, 1: one-`clk` pulse when `hc` becomes 0.
- `frame_start`, out, 1: one-`clk` pulse when (`hc`,`vc`) becomes (0,0).

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 800).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (default 525).
- Divider counter `div` runs 0..CLK_DIV-1 and wraps.
  - `pix_tick` is asserted in the cycle where `div` == CLK_DIV-1.
  - When CLK_DIV = 1, `pix_tick` is held high constantly.
- On each tick, `hc` increments.
  - `hc` == H_TOTAL-1 wraps to 0 and steps `vc`.
  - `vc` == V_TOTAL-1 wraps to 0.
  - `hc` and `vc` hold between ticks.
- Output decode is computed from the next counter values and registered, so every output matches the `hc`/`vc` shown in the same cycle:
  - `blank` = (`hc` ≥ H_ACTIVE) | (`vc` ≥ V_ACTIVE).
  - `hsync` is at `SYNC_ACTIVE` iff H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC (656..751).
  - `vsync` is at `SYNC_ACTIVE` iff V_ACTIVE+V_FP ≤ `vc` < V_ACTIVE+V_FP+V_SYNC (490..491).
  - `line_start` and `frame_start` are asserted only in the cycle where the counters load the wrap values.
- Arithmetic uses 11-bit unsigned compares. Parameter totals must be ≤ 2047; this is checked at elaboration.
- Asynchronous reset values:
  - `div` = 0, `hc` = 0, `vc` = 0, `blank` = 0.
  - `hsync` and `vsync` = ~SYNC_ACTIVE (deasserted).
  - `pix_tick`, `line_start` and `frame_start` = 0.
- Reset asserted mid-frame forces these values immediately. Counting resumes from (0,0) after release, with no partial-line recovery.

## Timing
- First `pix_tick` occurs CLK_DIV cycles after the first `clk` edge following `rst_n` release.
- `hc`, `vc` and all decoded outputs update on the `clk` edge that consumes the tick. Latency from tick to new coordinate is 1 `clk`.
- Outputs never glitch mid-pixel; every output is a flop output.
- Line period is H_TOTAL·CLK_DIV clocks (3200).
- Frame period is H_TOTAL·V_TOTAL·CLK_DIV clocks (1,680,000).
- `frame_start` implies `line_start` in the same cycle. Both are coincident with `pix_tick`'s following edge.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants;
  - the derived H_TOTAL/V_TOTAL function;
  - the coordinate width (11) shared with the sprite modules.
- Sub-module `pix_tick_gen` is the parameterised clock-enable divider, with inputs `clk`/`rst_n` and output `tick`. It is reused by other paced logic.
- The top level contains the two counters and the registered decode.

## Test plan
- Reset check: hold `rst_n`=0 → `hc`=0, `vc`=0, `blank`=0, `hsync`=`vsync`=1, all pulses 0. Release → first `pix_tick` exactly 4 clocks later. Subsequent ticks are every 4 clocks.
- Line wrap: run to `hc`=799, `vc`=9. The next tick gives `hc`=0, `vc`=10 and `line_start`=1 for one clock.
- Sync windows: `hsync` low for exactly `hc` 656..751 (96 pixels). `vsync` low for exactly `vc` 490..491. `blank` rises at `hc`=640 and at `vc`=480.
- Frame: `frame_start` pulses every 1,680,000 clocks, coincident with `line_start`, with `hc`=`vc`=0 in that cycle.
- Reset mid-frame: assert `rst_n`=0 at `hc`=300, `vc`=200 between clock edges. Outputs return to reset values without waiting for `clk`. After release, counting restarts at (0,0).
- CLK_DIV=1 build: `pix_tick` is constantly high, and `hc` increments every clock. Frame period is 420,000 clocks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the 640x480@60 display path.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned COORD_MAX = (1 << COORD_W) - 1;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CLK_DIV  = 4;

  // Total count of one axis: visible region plus both porches and the sync pulse.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Clock-enable divider: one-clk tick every CLK_DIV board clocks, constant high when CLK_DIV is 1.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pix_tick_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate h/v counters with registered, mutually aligned decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic tick;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  // Decode uses the next coordinates so every output lines up with hc/vc.
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d         = '0;
        line_start_d = 1'b1;
        if (vc_q == V_LAST) begin
          vc_d          = '0;
          frame_start_d = 1'b1;
        end else begin
          vc_d = vc_q + COORD_W'(1);
        end
      end else begin
        hc_d = hc_q + COORD_W'(1);
      end
    end
    blank_d = (hc_d >= H_VIS) || (vc_d >= V_VIS);
    hsync_d = ((hc_d >= HS_START) && (hc_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((vc_d >= VS_START) && (vc_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign blank       = blank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_tick    = tick;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (30x15) at CLK_DIV=4 and CLK_DIV=1.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Small raster: H 16+4+6+4=30 (hsync hc 20..25), V 8+2+2+3=15 (vsync vc 10..11).
  logic [10:0] a_hc, a_vc, b_hc, b_vc;
  logic a_blank, a_hs, a_vs, a_tick, a_ls, a_fs;
  logic b_blank, b_hs, b_vs, b_tick, b_ls, b_fs;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(4), .SYNC_ACTIVE(1'b0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .hc(a_hc), .vc(a_vc), .blank(a_blank),
    .hsync(a_hs), .vsync(a_vs), .pix_tick(a_tick),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(1), .SYNC_ACTIVE(1'b1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .hc(b_hc), .vc(b_vc), .blank(b_blank),
    .hsync(b_hs), .vsync(b_vs), .pix_tick(b_tick),
    .line_start(b_ls), .frame_start(b_fs)
  );

  typedef struct {
    int cyc; int hc; int vc; int blank; int hs; int vs; int tick; int ls; int fs;
  } vec_t;

  localparam int NV = 26;
  vec_t tab[NV];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a_hc"}, int'(a_hc), 0);
    chk({tag, " a_vc"}, int'(a_vc), 0);
    chk({tag, " a_blank"}, int'(a_blank), 0);
    chk({tag, " a_hsync"}, int'(a_hs), 1);
    chk({tag, " a_vsync"}, int'(a_vs), 1);
    chk({tag, " a_tick"}, int'(a_tick), 0);
    chk({tag, " a_line_start"}, int'(a_ls), 0);
    chk({tag, " a_frame_start"}, int'(a_fs), 0);
    chk({tag, " b_hsync"}, int'(b_hs), 0);
    chk({tag, " b_vsync"}, int'(b_vs), 0);
    chk({tag, " b_tick"}, int'(b_tick), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int found;
    int b_low;
    int fs_first;
    int fs_second;
    int fs_count;

    // Row n: expected state sampled after the n-th rising edge following reset release.
    tab = '{
      '{   1,  0,  0, 0, 1, 1, 0, 0, 0},
      '{   3,  0,  0, 0, 1, 1, 0, 0, 0},
      '{   4,  0,  0, 0, 1, 1, 1, 0, 0},
      '{   5,  1,  0, 0, 1, 1, 0, 0, 0},
      '{   8,  1,  0, 0, 1, 1, 1, 0, 0},
      '{  12,  2,  0, 0, 1, 1, 1, 0, 0},
      '{  64, 15,  0, 0, 1, 1, 1, 0, 0},
      '{  65, 16,  0, 1, 1, 1, 0, 0, 0},
      '{  80, 19,  0, 1, 1, 1, 1, 0, 0},
      '{  81, 20,  0, 1, 0, 1, 0, 0, 0},
      '{ 101, 25,  0, 1, 0, 1, 0, 0, 0},
      '{ 105, 26,  0, 1, 1, 1, 0, 0, 0},
      '{ 120, 29,  0, 1, 1, 1, 1, 0, 0},
      '{ 121,  0,  1, 0, 1, 1, 0, 1, 0},
      '{ 122,  0,  1, 0, 1, 1, 0, 0, 0},
      '{ 937, 24,  7, 1, 0, 1, 0, 0, 0},
      '{ 960, 29,  7, 1, 1, 1, 1, 0, 0},
      '{ 961,  0,  8, 1, 1, 1, 0, 1, 0},
      '{1200, 29,  9, 1, 1, 1, 1, 0, 0},
      '{1201,  0, 10, 1, 1, 0, 0, 1, 0},
      '{1321,  0, 11, 1, 1, 0, 0, 1, 0},
      '{1441,  0, 12, 1, 1, 1, 0, 1, 0},
      '{1800, 29, 14, 1, 1, 1, 1, 0, 0},
      '{1801,  0,  0, 0, 1, 1, 0, 1, 1},
      '{1802,  0,  0, 0, 1, 1, 0, 0, 0},
      '{3601,  0,  0, 0, 1, 1, 0, 1, 1}
    };

    // Hold reset across several edges, then release on a falling edge.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    n = 0;
    for (int i = 0; i < NV; i++) begin
      while (n < tab[i].cyc) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      chk($sformatf("row%0d(n=%0d) hc", i, tab[i].cyc), int'(a_hc), tab[i].hc);
      chk($sformatf("row%0d(n=%0d) vc", i, tab[i].cyc), int'(a_vc), tab[i].vc);
      chk($sformatf("row%0d(n=%0d) blank", i, tab[i].cyc), int'(a_blank), tab[i].blank);
      chk($sformatf("row%0d(n=%0d) hsync", i, tab[i].cyc), int'(a_hs), tab[i].hs);
      chk($sformatf("row%0d(n=%0d) vsync", i, tab[i].cyc), int'(a_vs), tab[i].vs);
      chk($sformatf("row%0d(n=%0d) pix_tick", i, tab[i].cyc), int'(a_tick), tab[i].tick);
      chk($sformatf("row%0d(n=%0d) line_start", i, tab[i].cyc), int'(a_ls), tab[i].ls);
      chk($sformatf("row%0d(n=%0d) frame_start", i, tab[i].cyc), int'(a_fs), tab[i].fs);
    end

    // Mid-frame reset: find (10,5), then drop rst_n between edges and look before the next edge.
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (a_hc == 11'd10 && a_vc == 11'd5) found = 1;
    end
    chk("midframe_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midframe_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from (0,0) for both builds; CLK_DIV=1 build ticks every clock.
    b_low = 0;
    fs_first = -1;
    fs_second = -1;
    fs_count = 0;
    for (n = 1; n <= 905; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_tick !== 1'b1) b_low++;
      if (b_fs === 1'b1) begin
        fs_count++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
      if (n == 1) begin
        chk("restart a_hc n=1", int'(a_hc), 0);
        chk("restart a_vc n=1", int'(a_vc), 0);
        chk("restart b_hc n=1", int'(b_hc), 0);
      end
      if (n == 3) chk("restart a_tick n=3", int'(a_tick), 0);
      if (n == 4) chk("restart a_tick n=4", int'(a_tick), 1);
      if (n == 5) begin
        chk("restart a_hc n=5", int'(a_hc), 1);
        chk("restart a_vc n=5", int'(a_vc), 0);
      end
      if (n == 2) chk("div1 b_hc n=2", int'(b_hc), 1);
      if (n == 16) chk("div1 b_blank hc15", int'(b_blank), 0);
      if (n == 17) chk("div1 b_blank hc16", int'(b_blank), 1);
      if (n == 20) chk("div1 b_hsync hc19", int'(b_hs), 0);
      if (n == 21) begin
        chk("div1 b_hc n=21", int'(b_hc), 20);
        chk("div1 b_hsync hc20", int'(b_hs), 1);
      end
      if (n == 26) chk("div1 b_hsync hc25", int'(b_hs), 1);
      if (n == 27) chk("div1 b_hsync hc26", int'(b_hs), 0);
      if (n == 301) begin
        chk("div1 b_vc n=301", int'(b_vc), 10);
        chk("div1 b_vsync vc10", int'(b_vs), 1);
        chk("div1 b_line_start n=301", int'(b_ls), 1);
      end
      if (n == 450) begin
        chk("div1 b_hc n=450", int'(b_hc), 29);
        chk("div1 b_vc n=450", int'(b_vc), 14);
      end
      if (n == 451) begin
        chk("div1 b_line_start n=451", int'(b_ls), 1);
        chk("div1 b_hc n=451", int'(b_hc), 0);
        chk("div1 b_vc n=451", int'(b_vc), 0);
      end
    end
    chk("div1 tick low cycles", b_low, 0);
    chk("div1 first frame_start", fs_first, 451);
    chk("div1 frame period", fs_second - fs_first, 450);
    chk("div1 frame_start count", fs_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
